// File: rtl/spi_slave_pkg.sv
// Shared definitions for the parametrised SPI slave front-end.
//   - command encodings carried in the top two bits of every frame
//   - FSM state encoding
//   - bit_rev(): reverses the low w bits of a value (used for LSB-first frames)
package spi_slave_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX_WAIT,
    ST_TX,
    ST_HOLD
  } state_e;

  localparam int REV_MAX_W = 64;

  // Reverse the whole 64-bit word, then shift the reversed low field back down.
  function automatic logic [REV_MAX_W-1:0] bit_rev(input logic [REV_MAX_W-1:0] v, input int w);
    logic [REV_MAX_W-1:0] r;
    for (int i = 0; i < REV_MAX_W; i++) begin
      r[i] = v[REV_MAX_W-1-i];
    end
    return r >> (REV_MAX_W - w);
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Read-response serialiser.
//   clk, rst : system clock, async active-high reset
//   load     : capture data into the shift register and restart the bit count
//   data     : parallel response word
//   enable   : drive the next bit onto miso this cycle
//   abort    : drop the transfer, force miso low
//   miso     : registered serial output, 0 whenever not shifting
//   last     : all TX_W bits have been driven
module spi_tx_shifter
  import spi_slave_pkg::*;
#(
  parameter int TX_W      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [TX_W-1:0] data,
  input  logic            enable,
  input  logic            abort,
  output logic            miso,
  output logic            last
);

  localparam int CNT_W = $clog2(TX_W + 1);

  logic [TX_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             miso_q, miso_d;

  assign last = (cnt_q == CNT_W'(TX_W));
  assign miso = miso_q;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    miso_d  = 1'b0;
    if (abort) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load) begin
      shreg_d = data;
      cnt_d   = '0;
    end else if (enable && !last) begin
      if (MSB_FIRST) begin
        miso_d  = shreg_q[TX_W-1];
        shreg_d = shreg_q << 1;
      end else begin
        miso_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      miso_q  <= miso_d;
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: deserialises {cmd[1:0], payload} frames from MOSI,
// strobes them out on rx_valid, and serialises read responses onto MISO.
//   clk, rst      : system/SPI bit clock, async active-high reset
//   SS_n, MOSI    : slave select (active low), serial data in
//   MISO          : registered serial data out
//   rx_data       : last accepted frame {cmd, payload}; rx_valid strobes it
//   tx_data       : read response word, taken when tx_valid in TX_WAIT
//   tx_done       : pulse after the last MISO bit
//   frame_err     : pulse when SS_n rises mid-frame
//   rd_err        : pulse when RD_DATA arrives without a preceding RD_ADDR
//   busy          : high in every state except IDLE
//
// state   | meaning
// IDLE    | waiting for SS_n low; first edge with SS_n low samples bit 0
// RX      | shifting in frame bits; decodes once FRAME_W bits are held
// TX_WAIT | RD_DATA accepted, waiting for tx_valid
// TX      | shifting the response out on MISO
// HOLD    | frame finished, ignoring MOSI until SS_n rises
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int TX_W      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [PAYLOAD_W+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [TX_W-1:0]      tx_data,
  input  logic                 tx_valid,
  output logic                 tx_done,
  output logic                 frame_err,
  output logic                 rd_err,
  output logic                 busy
);

  localparam int FRAME_W = PAYLOAD_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               tx_done_q, tx_done_d;
  logic               frame_err_q, frame_err_d;
  logic               rd_err_q, rd_err_d;
  logic               rd_armed_q, rd_armed_d;
  logic               busy_q, busy_d;

  logic               tx_load, tx_en, tx_abort, tx_last;
  logic [FRAME_W-1:0] frame_dec;
  logic [1:0]         cmd;

  // The first received bit always lands in the MSB of shift_q; LSB-first frames
  // therefore come out mirrored and are flipped back before decode.
  assign frame_dec = MSB_FIRST ? shift_q
                               : FRAME_W'(bit_rev(REV_MAX_W'(shift_q), FRAME_W));
  assign cmd       = frame_dec[FRAME_W-1 -: 2];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    rd_err_d    = 1'b0;
    rd_armed_d  = rd_armed_q;
    tx_load     = 1'b0;
    tx_en       = 1'b0;
    tx_abort    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!SS_n) begin
          shift_d   = {shift_q[FRAME_W-2:0], MOSI};
          bit_cnt_d = CNT_W'(1);
          state_d   = ST_RX;
        end
      end
      ST_RX: begin
        if (bit_cnt_q == CNT_W'(FRAME_W)) begin
          // Full frame held: accepted even if SS_n rises on this edge.
          case (cmd)
            CMD_WR_ADDR, CMD_WR_DATA: begin
              rx_data_d  = frame_dec;
              rx_valid_d = 1'b1;
              state_d    = ST_HOLD;
            end
            CMD_RD_ADDR: begin
              rx_data_d  = frame_dec;
              rx_valid_d = 1'b1;
              rd_armed_d = 1'b1;
              state_d    = ST_HOLD;
            end
            CMD_RD_DATA: begin
              if (rd_armed_q) begin
                rx_data_d  = frame_dec;
                rx_valid_d = 1'b1;
                state_d    = ST_TX_WAIT;
              end else begin
                rd_err_d = 1'b1;
                state_d  = ST_HOLD;
              end
            end
          endcase
          if (SS_n) state_d = ST_IDLE;
        end else if (SS_n) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          shift_d   = {shift_q[FRAME_W-2:0], MOSI};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_TX_WAIT: begin
        if (SS_n) begin
          tx_abort   = 1'b1;
          rd_armed_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (tx_valid) begin
          tx_load = 1'b1;
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        if (SS_n) begin
          tx_abort   = 1'b1;
          rd_armed_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (tx_last) begin
          tx_done_d  = 1'b1;
          rd_armed_d = 1'b0;
          state_d    = ST_HOLD;
        end else begin
          tx_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (SS_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_armed_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_done_q   <= tx_done_d;
      frame_err_q <= frame_err_d;
      rd_err_q    <= rd_err_d;
      rd_armed_q  <= rd_armed_d;
      busy_q      <= busy_d;
    end
  end

  spi_tx_shifter #(
    .TX_W      (TX_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .load   (tx_load),
    .data   (tx_data),
    .enable (tx_en),
    .abort  (tx_abort),
    .miso   (MISO),
    .last   (tx_last)
  );

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_done   = tx_done_q;
  assign frame_err = frame_err_q;
  assign rd_err    = rd_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_param.sv
module tb_spi_slave_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default build: PAYLOAD_W=8, TX_W=8, MSB first
  logic       ss_n = 1'b1, mosi = 1'b0, miso;
  logic [9:0] rx_data;
  logic       rx_valid, tx_done, frame_err, rd_err, busy;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  // LSB-first build: PAYLOAD_W=12, TX_W=16
  logic        ss_n_l = 1'b1, mosi_l = 1'b0, miso_l;
  logic [13:0] rx_data_l;
  logic        rx_valid_l, tx_done_l, frame_err_l, rd_err_l, busy_l;
  logic [15:0] tx_data_l = 16'h0000;
  logic        tx_valid_l = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_q[$];
  logic        bit_q[$];
  logic [9:0]  last_rx;

  spi_slave_param dut (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_done(tx_done), .frame_err(frame_err), .rd_err(rd_err), .busy(busy)
  );

  spi_slave_param #(.PAYLOAD_W(12), .TX_W(16), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .SS_n(ss_n_l), .MOSI(mosi_l), .MISO(miso_l),
    .rx_data(rx_data_l), .rx_valid(rx_valid_l), .tx_data(tx_data_l), .tx_valid(tx_valid_l),
    .tx_done(tx_done_l), .frame_err(frame_err_l), .rd_err(rd_err_l), .busy(busy_l)
  );

  // Drive a 10-bit frame MSB first; returns after the last bit is presented.
  task automatic shift_in(input logic [9:0] f);
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      ss_n = 1'b0;
      mosi = f[i];
    end
  endtask

  task automatic shift_in_l(input logic [13:0] f);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ss_n_l = 1'b0;
      mosi_l = f[i];
    end
  endtask

  // Send a frame and stop at the sample point after the decode edge.
  task automatic send_frame(input logic [9:0] f, input bit accept);
    if (accept) begin
      exp_q.push_back(14'(f));
      last_rx = f;
    end
    shift_in(f);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({miso, rx_valid, tx_done, frame_err, rd_err, busy} !== 6'b0 || rx_data !== 10'h0) begin
      errors++;
      $display("FAIL reset_default got miso=%b v=%b done=%b ferr=%b rderr=%b busy=%b d=%h want all 0",
               miso, rx_valid, tx_done, frame_err, rd_err, busy, rx_data);
    end
    checks++;
    if ({miso_l, rx_valid_l, tx_done_l, frame_err_l, rd_err_l, busy_l} !== 6'b0 || rx_data_l !== 14'h0) begin
      errors++;
      $display("FAIL reset_lsb got outputs=%b d=%h want all 0",
               {miso_l, rx_valid_l, tx_done_l, frame_err_l, rd_err_l, busy_l}, rx_data_l);
    end
    rst = 1'b0;
    last_rx = 10'h0;
  endtask

  task automatic test_write_addr;
    logic [13:0] exp_v;
    exp_q.push_back(14'h0A5);
    last_rx = 10'h0A5;
    shift_in(10'b00_1010_0101);
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL wr_rxv_early got %b want 0", rx_valid);
    end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp_v[9:0]) begin
      errors++; $display("FAIL wr_rx got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, exp_v[9:0]);
    end
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL wr_hold got v=%b busy=%b want v=0 busy=1", rx_valid, busy);
    end
    ss_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wr_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_rd_order;
    send_frame(10'b11_0000_0000, 1'b0);
    checks++;
    if (rd_err !== 1'b1 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL rdo_err got rd_err=%b v=%b want rd_err=1 v=0", rd_err, rx_valid);
    end
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_err !== 1'b0 || miso !== 1'b0) begin
      errors++; $display("FAIL rdo_pulse got rd_err=%b miso=%b want 0 0", rd_err, miso);
    end
    @(negedge clk);
    checks++;
    if (miso !== 1'b0 || tx_done !== 1'b0) begin
      errors++; $display("FAIL rdo_miso got miso=%b done=%b want 0 0", miso, tx_done);
    end
    tx_valid = 1'b0;
    ss_n = 1'b1;
  endtask

  task automatic test_read;
    logic [13:0] exp_v;
    logic        b;
    logic [7:0]  w;
    send_frame(10'b10_0000_0011, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp_v[9:0]) begin
      errors++; $display("FAIL rd_addr got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, exp_v[9:0]);
    end
    // tx_valid in HOLD must be ignored
    tx_data = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (miso !== 1'b0) begin
      errors++; $display("FAIL rd_hold_txv miso got %b want 0", miso);
    end
    tx_valid = 1'b0;
    ss_n = 1'b1;
    send_frame(10'b11_0101_1010, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp_v[9:0]) begin
      errors++; $display("FAIL rd_data got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, exp_v[9:0]);
    end
    w = 8'hC3;
    for (int k = 7; k >= 0; k--) bit_q.push_back(w[k]);
    tx_data = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (miso !== 1'b0) begin
      errors++; $display("FAIL rd_lat miso got %b want 0", miso);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b = bit_q.pop_front();
      checks++;
      if (miso !== b || tx_done !== 1'b0) begin
        errors++; $display("FAIL rd_bit%0d got miso=%b done=%b want miso=%b done=0", k, miso, tx_done, b);
      end
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b1 || miso !== 1'b0) begin
      errors++; $display("FAIL rd_done got done=%b miso=%b want 1 0", tx_done, miso);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rd_after got done=%b busy=%b want 0 1", tx_done, busy);
    end
    ss_n = 1'b1;
  endtask

  task automatic test_frame_abort;
    logic [13:0] exp_v;
    logic [9:0]  f;
    f = 10'b01_1011_0110;
    for (int i = 9; i >= 5; i--) begin
      @(negedge clk);
      ss_n = 1'b0;
      mosi = f[i];
    end
    @(negedge clk);
    ss_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b1 || rx_valid !== 1'b0 || rx_data !== last_rx || busy !== 1'b0) begin
      errors++; $display("FAIL abort_err got ferr=%b v=%b d=%h busy=%b want 1 0 %h 0",
                         frame_err, rx_valid, rx_data, busy, last_rx);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL abort_pulse got %b want 0", frame_err);
    end
    send_frame(10'b01_1111_0000, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp_v[9:0]) begin
      errors++; $display("FAIL abort_resync got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, exp_v[9:0]);
    end
    ss_n = 1'b1;
  endtask

  task automatic test_tx_abort;
    logic [13:0] exp_v;
    send_frame(10'b10_0000_0001, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp_v[9:0]) begin
      errors++; $display("FAIL txa_addr got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, exp_v[9:0]);
    end
    ss_n = 1'b1;
    send_frame(10'b11_0000_0000, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp_v[9:0]) begin
      errors++; $display("FAIL txa_data got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, exp_v[9:0]);
    end
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (miso !== 1'b1) begin
        errors++; $display("FAIL txa_bit%0d got %b want 1", k, miso);
      end
    end
    ss_n = 1'b1;
    @(negedge clk);
    checks++;
    if (miso !== 1'b0 || tx_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL txa_cut got miso=%b done=%b busy=%b want 0 0 0", miso, tx_done, busy);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0) begin
      errors++; $display("FAIL txa_nodone got %b want 0", tx_done);
    end
    send_frame(10'b11_1111_1111, 1'b0);
    checks++;
    if (rd_err !== 1'b1 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL txa_disarm got rd_err=%b v=%b want 1 0", rd_err, rx_valid);
    end
    ss_n = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [13:0] exp_v;
    send_frame(10'b10_0101_0101, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp_v[9:0]) begin
      errors++; $display("FAIL rstm_addr got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, exp_v[9:0]);
    end
    ss_n = 1'b1;
    send_frame(10'b11_1010_1010, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp_v[9:0]) begin
      errors++; $display("FAIL rstm_data got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, exp_v[9:0]);
    end
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (miso !== 1'b1) begin
      errors++; $display("FAIL rstm_pre miso got %b want 1", miso);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({miso, rx_valid, tx_done, frame_err, rd_err, busy} !== 6'b0 || rx_data !== 10'h0) begin
      errors++; $display("FAIL rstm_async got outputs=%b d=%h want all 0",
                         {miso, rx_valid, tx_done, frame_err, rd_err, busy}, rx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    ss_n = 1'b1;
    last_rx = 10'h0;
    @(negedge clk);
    send_frame(10'b11_0000_0001, 1'b0);
    checks++;
    if (rd_err !== 1'b1 || rx_valid !== 1'b0 || rx_data !== last_rx) begin
      errors++; $display("FAIL rstm_disarm got rd_err=%b v=%b d=%h want 1 0 %h", rd_err, rx_valid, rx_data, last_rx);
    end
    ss_n = 1'b1;
  endtask

  task automatic test_lsb;
    logic [13:0] exp_v;
    logic [13:0] f;
    logic [15:0] words [2];
    logic        b;
    words[0] = 16'h8001;
    words[1] = 16'h1234;
    f = {2'b01, 12'hABC};
    exp_q.push_back(f);
    shift_in_l(f);
    @(negedge clk);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if (rx_valid_l !== 1'b1 || rx_data_l !== exp_v) begin
      errors++; $display("FAIL lsb_wr got v=%b d=%h want v=1 d=%h", rx_valid_l, rx_data_l, exp_v);
    end
    ss_n_l = 1'b1;
    for (int n = 0; n < 2; n++) begin
      f = {2'b10, 12'h123};
      exp_q.push_back(f);
      shift_in_l(f);
      @(negedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (rx_valid_l !== 1'b1 || rx_data_l !== exp_v) begin
        errors++; $display("FAIL lsb_addr%0d got v=%b d=%h want v=1 d=%h", n, rx_valid_l, rx_data_l, exp_v);
      end
      ss_n_l = 1'b1;
      f = {2'b11, 12'h00F};
      exp_q.push_back(f);
      shift_in_l(f);
      @(negedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (rx_valid_l !== 1'b1 || rx_data_l !== exp_v) begin
        errors++; $display("FAIL lsb_data%0d got v=%b d=%h want v=1 d=%h", n, rx_valid_l, rx_data_l, exp_v);
      end
      for (int k = 0; k < 16; k++) bit_q.push_back(words[n][k]);
      tx_data_l = words[n];
      tx_valid_l = 1'b1;
      @(negedge clk);
      tx_valid_l = 1'b0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        b = bit_q.pop_front();
        checks++;
        if (miso_l !== b) begin
          errors++; $display("FAIL lsb_tx%0d_bit%0d got %b want %b", n, k, miso_l, b);
        end
      end
      @(negedge clk);
      checks++;
      if (tx_done_l !== 1'b1 || miso_l !== 1'b0) begin
        errors++; $display("FAIL lsb_done%0d got done=%b miso=%b want 1 0", n, tx_done_l, miso_l);
      end
      ss_n_l = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_rd_order();
    test_read();
    test_frame_abort();
    test_tx_abort();
    test_reset_mid();
    test_lsb();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave front-end for the register/memory access path. It deserialises a command-plus-payload frame from MOSI and presents it to the downstream memory controller with a one-cycle `rx_valid` strobe. For read-data frames it accepts a parallel word on `tx_valid` and serialises it onto MISO. Compared with the fixed 10-bit slave, it adds configurable payload, response width and bit order, read-sequence checking, and explicit framing and read-order error flags.

## Interface
Parameters:
- `PAYLOAD_W`, default 8: payload bits per frame. Frame length `FRAME_W = PAYLOAD_W + 2`.
- `TX_W`, default 8: width of the read response word.
- `MSB_FIRST`, default 1: 1 sends and receives MSB first; 0 sends and receives LSB first. Applies to both directions, command bits included.

Ports:
- `clk` input, 1 bit: system clock. The SPI bit clock is the same as `clk`.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `SS_n` input, 1 bit: slave select, active low.
- `MOSI` input, 1 bit: serial data in.
- `MISO` output, 1 bit: serial data out, registered.
- `rx_data` output, `FRAME_W` bits: received frame as {cmd[1:0], payload}.
- `rx_valid` output, 1 bit: one-cycle strobe; `rx_data` is valid while it is high.
- `tx_data` input, `TX_W` bits: read response word.
- `tx_valid` input, 1 bit: `tx_data` is valid.
- `tx_done` output, 1 bit: one-cycle pulse after the last MISO bit.
- `frame_err` output, 1 bit: one-cycle pulse when a frame is aborted.
- `rd_err` output, 1 bit: one-cycle pulse on a read-order violation.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
Command encodings (`cmd`):
- 00 WR_ADDR
- 01 WR_DATA
- 10 RD_ADDR
- 11 RD_DATA

States:
- **IDLE**
  - `SS_n`=0: sample MOSI as frame bit 0 and go to RX with `bit_cnt`=1.
- **RX**
  - Sample one MOSI bit per cycle into the shift register.
  - When `bit_cnt` reaches `FRAME_W`, register `rx_data` and decode `cmd`:
  - cmd 00/01: pulse `rx_valid`, go to HOLD.
  - cmd 10: pulse `rx_valid`, set `rd_armed`, go to HOLD.
  - cmd 11 with `rd_armed`=1: pulse `rx_valid`, go to TX_WAIT.
  - cmd 11 with `rd_armed`=0: pulse `rd_err`, no `rx_valid`, go to HOLD.
- **TX_WAIT**
  - `tx_valid`=1: load `tx_data` into the TX shifter and go to TX.
- **TX**
  - Drive one bit per cycle on MISO for `TX_W` cycles.
  - Then pulse `tx_done`, clear `rd_armed`, go to HOLD.
- **HOLD**
  - Ignore MOSI; `MISO`=0; wait for `SS_n`=1.

Applies in every state:
- `SS_n`=1 forces IDLE on the next edge.
- If this happens in RX with 1 ≤ `bit_cnt` < `FRAME_W`, pulse `frame_err` and leave `rx_data` unchanged.
- If it happens in TX_WAIT or TX, the transfer is aborted, `rd_armed` is cleared, and no `tx_done` is issued.

Data rules:
- `rx_data` holds its last value until the next valid frame.
- When `MSB_FIRST`=0, the received frame is bit-reversed before decode.
- `rd_armed` persists across `SS_n` deassertion. It is cleared only by reset, `tx_done`, or a TX abort.

## Timing
- Reset values: `MISO`=0, `rx_data`=0, `rx_valid`=0, `tx_done`=0, `frame_err`=0, `rd_err`=0, `busy`=0, `rd_armed`=0, state IDLE.
- Frame bits are sampled on the `FRAME_W` consecutive edges starting with the first edge where `SS_n`=0.
- `rx_valid` is high exactly one cycle, on the edge after the last frame bit. A frame is accepted even if `SS_n` rises on that same edge.
- TX latency:
  - `tx_valid` is sampled high at edge T.
  - The first MISO bit is valid from T+1.
  - Bit k is driven at T+1+k.
  - `tx_done` is high during T+1+`TX_W`.
- `tx_valid` outside TX_WAIT is ignored.
- If `SS_n`=1 and `tx_valid`=1 on the same edge, `SS_n` wins.
- Minimum `SS_n` high time between frames: 1 cycle.

## Structure
- Package `spi_slave_pkg` contains:
  - command encodings;
  - the state enum (IDLE, RX, TX_WAIT, TX, HOLD);
  - a bit-reverse function.
- Sub-module `spi_tx_shifter` (parameter `TX_W`, `MSB_FIRST`):
  - ports: load, data, enable, abort;
  - outputs: MISO, last.
- Top level contains the FSM, RX shift register, bit counter and `rd_armed` flag. Target size is roughly 200 lines of RTL.

## Test plan
- **Write address:** `PAYLOAD_W`=8, send 00_1010_0101 MSB first → `rx_valid` for one cycle at edge 10 with `rx_data`=0x0A5. `busy` stays high until `SS_n` rises.
- **Read sequence:**
  - Send RD_ADDR 10_0000_0011 → `rx_valid`.
  - Send RD_DATA 11_xxxx_xxxx → `rx_valid`.
  - Drive `tx_valid` with `tx_data`=0xC3 → MISO shows 1,1,0,0,0,0,1,1 on the next 8 cycles, then `tx_done` pulses.
- **Read-order error:** after reset, send RD_DATA with no RD_ADDR → `rd_err` pulses once, no `rx_valid`, MISO stays 0.
- **Frame abort:** raise `SS_n` after 5 bits → `frame_err` pulses once, `rx_data` unchanged, state returns to IDLE.
- **TX abort and reset:**
  - Raise `SS_n` after the 3rd MISO bit → no `tx_done`, MISO=0 from the next edge, and a following RD_DATA gives `rd_err`.
  - Assert `rst` mid-frame → all outputs 0 immediately, without waiting for a clock edge.
- **LSB-first build:** `MSB_FIRST`=0, `PAYLOAD_W`=12, `TX_W`=16 → round-trip of 0xABC and TX word 0x8001 with bit order reversed.
